// File: rtl/pwm_fader.sv
// Breathing-LED duty generator: prescaled step pulses and a ramp-up / hold / ramp-down / hold
// duty envelope, intended to drive the step and duty inputs of the pwm block.
module pwm_fader #(
    parameter int N        = 8,
    parameter int PRESCALE = 1000,
    parameter int HOLD_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [N-1:0]      inc,
    input  logic [15:0]       fade_div,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              step,
    output logic [N-1:0]      duty,
    output logic [2:0]        state,
    output logic              peak,
    output logic              cycle_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [N-1:0]  MAX      = '1;
    localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } state_t;

    // Saturating step helpers: the duty word clamps at MAX going up and at 0 going down.
    function automatic logic [N-1:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, MAX}) ? MAX : s[N-1:0];
    endfunction

    function automatic logic [N-1:0] sat_sub(input logic [N-1:0] a, input logic [N-1:0] b);
        return (a <= b) ? '0 : a - b;
    endfunction

    state_t              state_q, state_n;
    logic [N-1:0]        duty_q, duty_n;
    logic [PW-1:0]       pre_cnt, pre_n;
    logic [15:0]         div_cnt, div_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic                step_q, step_n;
    logic                peak_q, peak_n;
    logic                done_q, done_n;

    logic                tick, fade_tick;
    logic [15:0]         fdiv;
    logic [N-1:0]        inc_e;
    logic [N-1:0]        up_val, down_val;

    assign tick      = ena && (pre_cnt == PRE_LAST);
    assign fdiv      = (fade_div == 16'd0) ? 16'd1 : fade_div;
    assign fade_tick = tick && (div_cnt == fdiv - 16'd1);
    assign inc_e     = (inc == '0) ? ONE : inc;
    assign up_val    = sat_add(duty_q, inc_e);
    assign down_val  = sat_sub(duty_q, inc_e);

    always_comb begin
        state_n = state_q;
        duty_n  = duty_q;
        pre_n   = pre_cnt;
        div_n   = div_cnt;
        hold_n  = hold_cnt;
        step_n  = 1'b0;
        peak_n  = 1'b0;
        done_n  = 1'b0;

        if (!ena) begin
            state_n = IDLE;
            duty_n  = '0;
            pre_n   = '0;
            div_n   = '0;
            hold_n  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Counters stay at 0 so the first step lands exactly PRESCALE cycles later.
                    state_n = RAMP_UP;
                    duty_n  = '0;
                    pre_n   = '0;
                    div_n   = '0;
                    hold_n  = '0;
                end
                RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW: begin
                    pre_n  = tick ? '0 : pre_cnt + PW'(1);
                    step_n = tick;
                    if (tick) div_n = fade_tick ? 16'd0 : div_cnt + 16'd1;
                    if (fade_tick) begin
                        case (state_q)
                            RAMP_UP: begin
                                duty_n = up_val;
                                if (up_val == MAX) begin
                                    state_n = HOLD_HIGH;
                                    hold_n  = '0;
                                    peak_n  = 1'b1;
                                end
                            end
                            RAMP_DOWN: begin
                                duty_n = down_val;
                                if (down_val == '0) begin
                                    state_n = HOLD_LOW;
                                    hold_n  = '0;
                                end
                            end
                            HOLD_HIGH, HOLD_LOW: begin
                                if (hold_cnt == hold_cycles) begin
                                    hold_n = '0;
                                    if (state_q == HOLD_HIGH) begin
                                        state_n = RAMP_DOWN;
                                    end else begin
                                        state_n = RAMP_UP;
                                        done_n  = 1'b1;
                                    end
                                end else begin
                                    hold_n = hold_cnt + HOLD_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state_n = IDLE;
                    duty_n  = '0;
                    pre_n   = '0;
                    div_n   = '0;
                    hold_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            pre_cnt  <= '0;
            div_cnt  <= '0;
            hold_cnt <= '0;
            step_q   <= 1'b0;
            peak_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            duty_q   <= duty_n;
            pre_cnt  <= pre_n;
            div_cnt  <= div_n;
            hold_cnt <= hold_n;
            step_q   <= step_n;
            peak_q   <= peak_n;
            done_q   <= done_n;
        end
    end

    assign step       = step_q;
    assign duty       = duty_q;
    assign state      = state_q;
    assign peak       = peak_q;
    assign cycle_done = done_q;

endmodule
